// File: rtl/line_window_feeder.sv
// line_window_feeder: turns a raster pixel stream into vertical 3-pixel columns.
// Ports: pixel_in/pixel_valid/frame_start in; top/mid/bot columns, position, window/line/frame flags out.
// Optional macro LINE_WINDOW_BORDER_REPLICATE_EN replicates the top border rows.
module line_window_feeder #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [PIX_W-1:0]              pixel_in,
  input  logic                          pixel_valid,
  input  logic                          frame_start,
  output logic [PIX_W-1:0]              top_out,
  output logic [PIX_W-1:0]              mid_out,
  output logic [PIX_W-1:0]              bot_out,
  output logic                          col_valid,
  output logic                          window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_idx,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_idx,
  output logic                          line_done,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] c_q, c_d, pos_c;
  logic [RW-1:0] r_q, r_d, pos_r;

  logic [PIX_W-1:0] lb_a [IMG_WIDTH];
  logic [PIX_W-1:0] lb_b [IMG_WIDTH];
  logic [PIX_W-1:0] rd_a, rd_b;
  logic [PIX_W-1:0] top_d, mid_d;

  logic accept, last_c, last_r, wv_d;

  // A frame_start beat always restarts at (0,0), even mid-frame.
  assign accept = pixel_valid
                & (frame_start | (state_q != IDLE));
  assign pos_c  = frame_start ? '0 : c_q;
  assign pos_r  = frame_start ? '0 : r_q;
  assign last_c = (pos_c == C_LAST);
  assign last_r = (pos_r == R_LAST);
  assign rd_a   = lb_a[pos_c];
  assign rd_b   = lb_b[pos_c];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    if (accept) begin
      c_d = last_c ? '0 : pos_c + CW'(1);
      if (last_c)
        r_d = last_r ? '0 : pos_r + RW'(1);
      else
        r_d = pos_r;
      unique case (1'b1)
        last_c && last_r:
          state_d = IDLE;
        last_c && (pos_r == RW'(1)):
          state_d = STREAM;
        frame_start:
          state_d = FILL;
        default:
          state_d = state_q;
      endcase
    end
  end

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
  // Rows 0/1 have no real lines above; mirror the nearest valid line.
  always_comb begin
    top_d = rd_b;
    mid_d = rd_a;
    if (pos_r == '0) begin
      top_d = pixel_in;
      mid_d = pixel_in;
    end else if (pos_r == RW'(1)) begin
      top_d = rd_a;
    end
  end
  assign wv_d = (pos_c >= CW'(2));
`else
  assign top_d = rd_b;
  assign mid_d = rd_a;
  assign wv_d  = (pos_c >= CW'(2))
               & (pos_r >= RW'(2));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
    end
  end

  // Line memories stay uninitialised; FILL rewrites them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[pos_c] <= pixel_in;
      lb_b[pos_c] <= rd_a;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_out      <= '0;
      mid_out      <= '0;
      bot_out      <= '0;
      col_valid    <= 1'b0;
      window_valid <= 1'b0;
      col_idx      <= '0;
      row_idx      <= '0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      col_valid    <= accept;
      window_valid <= accept & wv_d;
      line_done    <= accept & last_c;
      frame_done   <= accept & last_c & last_r;
      if (accept) begin
        top_out <= top_d;
        mid_out <= mid_d;
        bot_out <= pixel_in;
        col_idx <= pos_c;
        row_idx <= pos_r;
      end
    end
  end

endmodule
